// File: rtl/dma_pkg.sv
// Shared definitions for the tiny_dma command path: sequencer states, cfg bus
// bit positions and the helper that packs a descriptor into a start word.
package dma_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2
  } seq_state_t;

  localparam int CMD_W      = 7;
  localparam int CFG_START  = 7;
  localparam int CFG_SRC_HI = 6;
  localparam int CFG_SRC_LO = 4;
  localparam int CFG_DST_HI = 3;
  localparam int CFG_DST_LO = 1;
  localparam int CFG_MODE   = 0;

  function automatic logic [7:0] make_start_cfg(input logic [CMD_W-1:0] desc);
    logic [7:0] cfg;
    cfg = '0;
    cfg[CFG_START]             = 1'b1;
    cfg[CFG_SRC_HI:CFG_SRC_LO] = desc[6:4];
    cfg[CFG_DST_HI:CFG_DST_LO] = desc[3:1];
    cfg[CFG_MODE]              = desc[0];
    return cfg;
  endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Descriptor FIFO for the command sequencer. A push is accepted when not full,
// or when full but a pop frees a slot in the same cycle; flush wins over push.
module dma_cmd_fifo
  import dma_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_cmd_sequencer.sv
// Queues descriptors pushed from the pins and issues them one at a time to
// tiny_dma as single-cycle start words, with a watchdog on the done pulse.
module dma_cmd_sequencer
  import dma_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cmd_in,
  input  logic       cmd_push,
  input  logic       cmd_flush,
  input  logic       dma_done,
  output logic [7:0] cfg_out,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       timeout
);

  seq_state_t       state;
  logic             push_q;
  logic             push_ev;
  logic             pop;
  logic [CMD_W-1:0] head;
  logic [7:0]       wd;

  assign push_ev = cmd_push & ~push_q;
  assign pop     = (state == SEQ_IDLE) & ~empty;

  dma_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ev),
    .pop  (pop),
    .flush(cmd_flush),
    .wdata(cmd_in),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // A dropped push only counts as overflow when flush did not claim it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      push_q <= cmd_push;
      if (push_ev && !cmd_flush && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SEQ_IDLE;
      cfg_out <= 8'h00;
      busy    <= 1'b0;
      wd      <= 8'h00;
      timeout <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (!empty) begin
            cfg_out <= make_start_cfg(head);
            busy    <= 1'b1;
            state   <= SEQ_ISSUE;
          end else begin
            cfg_out <= 8'h00;
          end
        end
        SEQ_ISSUE: begin
          cfg_out <= 8'h00;
          wd      <= 8'h00;
          state   <= SEQ_WAIT;
        end
        SEQ_WAIT: begin
          if (dma_done) begin
            busy  <= 1'b0;
            state <= SEQ_IDLE;
          end else if (wd == 8'(TIMEOUT)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= SEQ_IDLE;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: begin
          cfg_out <= 8'h00;
          busy    <= 1'b0;
          state   <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer; dma_done is driven by hand to play tiny_dma.
module tb_dma_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cmd_in;
  logic       cmd_push;
  logic       cmd_flush;
  logic       dma_done;
  logic [7:0] cfg_out;
  logic       busy;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       timeout;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dma_cmd_sequencer #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_in   (cmd_in),
    .cmd_push (cmd_push),
    .cmd_flush(cmd_flush),
    .dma_done (dma_done),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .timeout  (timeout)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rising edge on cmd_push, then release; returns two edges later.
  task automatic applyStimulus(input logic [6:0] desc);
    cmd_in   = desc;
    cmd_push = 1'b1;
    tick();
    cmd_push = 1'b0;
    tick();
  endtask

  // Called while in WAIT: done pulse, then the next start must follow two edges later.
  task automatic doneThenExpect(input string tag, input logic [7:0] exp_cfg);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    checkOutput({tag, "_busy_low"}, {7'b0, busy}, 8'h00);
    tick();
    checkOutput({tag, "_cfg"}, cfg_out, exp_cfg);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] run aborted");
  end

  initial begin
    rst       = 1'b0;
    cmd_in    = 7'h00;
    cmd_push  = 1'b0;
    cmd_flush = 1'b0;
    dma_done  = 1'b0;
    repeat (3) tick();
    checkOutput("rst_cfg", cfg_out, 8'h00);
    checkOutput("rst_flags", {2'b0, busy, empty, full, overflow, timeout, 1'b0}, 8'b0001_0000);
    rst = 1'b1;
    tick();

    $display("[TB] single transfer");
    cmd_in   = 7'h08;
    cmd_push = 1'b1;
    tick();
    checkOutput("t1_entry_visible", {7'b0, empty}, 8'h00);
    checkOutput("t1_no_start_yet", cfg_out, 8'h00);
    cmd_push = 1'b0;
    tick();
    checkOutput("t1_start", cfg_out, 8'h88);
    checkOutput("t1_busy", {7'b0, busy}, 8'h01);
    tick();
    checkOutput("t1_pulse_end", cfg_out, 8'h00);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    checkOutput("t1_busy_fall", {7'b0, busy}, 8'h00);
    tick();
    checkOutput("t1_idle_cfg", cfg_out, 8'h00);

    $display("[TB] queued transfers");
    applyStimulus(7'h08);
    checkOutput("t2_first", cfg_out, 8'h88);
    applyStimulus(7'h1B);
    applyStimulus(7'h21);
    checkOutput("t2_hold_while_busy", {cfg_out[7], busy, empty, 5'b0}, 8'b0100_0000);
    doneThenExpect("t2_second", 8'h9B);
    repeat (3) tick();
    checkOutput("t2_no_extra_start", cfg_out, 8'h00);
    doneThenExpect("t2_third", 8'hA1);
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();
    checkOutput("t2_drained", {cfg_out[7], busy, empty, 5'b0}, 8'b0010_0000);

    $display("[TB] held push");
    cmd_in   = 7'h35;
    cmd_push = 1'b1;
    tick();
    tick();
    checkOutput("t4_start", cfg_out, 8'hB5);
    repeat (8) tick();
    checkOutput("t4_one_entry", {7'b0, empty}, 8'h01);
    cmd_push = 1'b0;
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();
    tick();
    checkOutput("t4_no_second", cfg_out, 8'h00);

    $display("[TB] watchdog");
    applyStimulus(7'h12);
    checkOutput("t5_start", cfg_out, 8'h92);
    applyStimulus(7'h2D);
    repeat (TIMEOUT - 1) tick();
    checkOutput("t5_not_yet", {7'b0, timeout}, 8'h00);
    tick();
    checkOutput("t5_expired", {6'b0, timeout, busy}, 8'h02);
    tick();
    checkOutput("t5_next_issued", cfg_out, 8'hAD);
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();

    $display("[TB] flush");
    applyStimulus(7'h01);
    checkOutput("t6_start", cfg_out, 8'h81);
    applyStimulus(7'h02);
    applyStimulus(7'h03);
    applyStimulus(7'h04);
    applyStimulus(7'h05);
    checkOutput("t6_full_before", {7'b0, full}, 8'h01);
    cmd_in    = 7'h06;
    cmd_push  = 1'b1;
    cmd_flush = 1'b1;
    tick();
    cmd_flush = 1'b0;
    cmd_push  = 1'b0;
    checkOutput("t6_after_flush", {4'b0, busy, empty, full, overflow}, 8'b0000_1100);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    tick();
    checkOutput("t6_no_start", cfg_out, 8'h00);
    tick();
    checkOutput("t6_idle", {6'b0, busy, empty}, 8'h01);

    $display("[TB] full and overflow");
    applyStimulus(7'h08);
    checkOutput("t3_start", cfg_out, 8'h88);
    applyStimulus(7'h11);
    applyStimulus(7'h22);
    applyStimulus(7'h33);
    checkOutput("t3_three_queued", {6'b0, full, overflow}, 8'h00);
    applyStimulus(7'h44);
    checkOutput("t3_full", {6'b0, full, overflow}, 8'h02);
    applyStimulus(7'h55);
    checkOutput("t3_overflow", {6'b0, full, overflow}, 8'h03);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    cmd_in   = 7'h66;
    cmd_push = 1'b1;
    tick();
    cmd_push = 1'b0;
    checkOutput("t3_pop_issue", cfg_out, 8'h91);
    checkOutput("t3_still_full", {7'b0, full}, 8'h01);
    tick();
    doneThenExpect("t3_d2", 8'hA2);
    tick();
    doneThenExpect("t3_d3", 8'hB3);
    tick();
    doneThenExpect("t3_d4", 8'hC4);
    tick();
    doneThenExpect("t3_push_with_pop", 8'hE6);
    tick();

    $display("[TB] reset mid-wait");
    applyStimulus(7'h0A);
    checkOutput("t7_pre_reset", {4'b0, busy, empty, overflow, timeout}, 8'b0000_1011);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t7_rst_cfg", cfg_out, 8'h00);
    checkOutput("t7_rst_flags", {2'b0, busy, empty, full, overflow, timeout, 1'b0}, 8'b0001_0000);
    tick();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("t7_queue_lost", {cfg_out[7], empty, 6'b0}, 8'b0100_0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
